serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
Parametrised bit-serial adder/subtractor. One full-adder cell processes WIDTH-bit operands LSB-first, one bit per clock, so the area stays constant as width grows.
Adds subtract mode, signed-overflow detection and a start/busy/done handshake. The single-bit full-adder has none of these.
Used wherever a wide add/sub is needed, throughput is not critical, and gate count matters.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..64.
CNT_W, $clog2(WIDTH), width of the internal bit counter; derived, not overridden.

Ports:
clk  input  1  system clock, rising edge active
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled on a rising edge only while busy=0
sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1, cin ignored); captured with operands
a  input  WIDTH  operand A, captured on the accepted start edge
b  input  WIDTH  operand B, captured on the accepted start edge
cin  input  1  carry-in, add mode only, captured on the accepted start edge
busy  output  1  operation in progress
done  output  1  one-cycle pulse: result registers updated
sum  output  WIDTH  result, held stable until the next completion
cout  output  1  carry-out; in sub mode 1 = no borrow (a >= b unsigned)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset values (async assert): busy=0, done=0, sum=0, cout=0, ovf=0. Internal counter, shift registers and carry are also cleared.
- Reset mid-operation aborts the operation. No done pulse is produced. sum/cout/ovf return to 0.
- Accept (edge E0): start=1 and busy=0.
  - Load shift register A with a.
  - Load shift register B with b (sub=0) or ~b (sub=1).
  - Carry register <= cin (sub=0) or 1 (sub=1).
  - Counter <= 0; busy <= 1.
- Compute (edges E1..E_WIDTH, busy=1), per edge:
  - s = A[0]^B[0]^carry.
  - carry <= A[0]&B[0] | carry&(A[0]^B[0]).
  - Shift s into the MSB of the internal result register; shift A and B right by one.
  - Counter increments.
  - On the edge that processes bit WIDTH-1, also latch carry-in-to-MSB for overflow.
- Complete (edge E_WIDTH):
  - sum <= final result register including bit WIDTH-1.
  - cout <= carry out of bit WIDTH-1.
  - ovf <= carry into MSB XOR carry out of MSB.
  - busy <= 0; done <= 1 for exactly one cycle.
- Latency: done is high in the cycle after E_WIDTH, i.e. WIDTH clocks after the accepting edge.
  - busy is high for exactly WIDTH cycles.
  - Throughput is one operation per WIDTH clocks.
- start while busy=1: ignored. No queueing; operands and mode are not re-sampled.
- start in the done cycle (busy=0): accepted. Back-to-back operations are allowed. done falls the next cycle; sum holds the old result until the new completion.
- sum/cout/ovf change only at completion or reset. They are never visible mid-shift.
- Inputs a, b, cin, sub may change freely while busy without effect.
- Width rules: no sign extension. cout/ovf are the only indication of result range exceeding WIDTH.

Test Plan:
- Reset: assert rst mid-clock with no clk edge -> busy=0, done=0, sum=0x00, cout=0, ovf=0 immediately.
- Add, WIDTH=8:
  - a=0x5A, b=0x3C, sub=0, cin=0 -> sum=0x96, cout=0, ovf=1.
  - busy high 8 cycles; done pulse exactly 8 clocks after the start edge.
- Add wrap: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, ovf=0.
- Subtract:
  - a=0x10, b=0x20, sub=1, cin=1 (ignored) -> sum=0xF0, cout=0, ovf=0.
  - a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
- Handshake:
  - start with a=0x01, b=0x01; pulse start again at cycle 3 with a=0xAA -> ignored; result sum=0x02.
  - Next start asserted in the done cycle with a=0x03, b=0x04 -> accepted; sum stays 0x02 until the second done, then 0x07.
- Abort: start a=0x12, b=0x34, assert rst at cycle 4 -> no done; outputs 0. After release, a=0x12+0x34 completes normally -> sum=0x46.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell walks WIDTH-bit operands
// LSB-first, one bit per clock, behind a start/busy/done handshake.
module serial_addsub #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic             load;
  logic             step;
  logic             last;

  logic [WIDTH-1:0] sha;
  logic [WIDTH-1:0] shb;
  logic [WIDTH-1:0] shr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             s_bit;
  logic             c_next;

  // Handshake: a start is accepted only on an edge where busy=0; while busy
  // the start input and all operand inputs are ignored. done is a one-cycle
  // pulse on the cycle after the edge that writes sum/cout/ovf.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (cnt == LAST_BIT) begin
          last    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_RUN);

  // The single full-adder cell shared by every bit position.
  assign s_bit  = sha[0] ^ shb[0] ^ carry;
  assign c_next = (sha[0] & shb[0]) | (carry & (sha[0] ^ shb[0]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sha   <= '0;
      shb   <= '0;
      shr   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
        sha   <= a;
        shb   <= sub ? ~b : b;
        carry <= sub ? 1'b1 : cin;
        cnt   <= '0;
      end else if (step) begin
        sha   <= sha >> 1;
        shb   <= shb >> 1;
        shr   <= {s_bit, shr[WIDTH-1:1]};
        carry <= c_next;
        cnt   <= cnt + CNT_W'(1);
        if (last) begin
          // carry still holds the carry into the MSB on this edge.
          sum  <= {s_bit, shr[WIDTH-1:1]};
          cout <= c_next;
          ovf  <= carry ^ c_next;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: stimulus pushes expected results into a
// queue, a monitor pops and compares whenever done pulses.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  logic [W+1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] last_sum = '0;
  logic [W-1:0] next_sum = '0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: actual sum=0x%0h with no expected result queued", sum);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        if ({sum, cout, ovf} !== e) begin
          errors++;
          $display("FAIL result: actual sum=0x%0h cout=%0b ovf=%0b required sum=0x%0h cout=%0b ovf=%0b",
                   sum, cout, ovf, e[W+1:2], e[1], e[0]);
        end
      end
    end
  end

  // driver tasks
  // Drives an operation; returns 1 ns after its accepting edge.
  task automatic launch(input logic now, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tcin, input logic tsub, input logic [W-1:0] esum,
                        input logic ecout, input logic eovf);
    if (!now) @(negedge clk);
    a     = ta;
    b     = tb_v;
    cin   = tcin;
    sub   = tsub;
    start = 1'b1;
    exp_q.push_back({esum, ecout, eovf});
    next_sum = esum;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom_range(0, 255);
    b     = $urandom_range(0, 255);
    check("busy_after_accept", 64'(busy), 64'd1);
  endtask

  // Waits for done; checks latency, busy duration and that sum holds mid-shift.
  // poke_at >= 0 pulses start with junk operands while busy.
  task automatic wait_done(input int poke_at);
    int k;
    int busy_cnt;
    k = 0;
    busy_cnt = 1;
    while (k < 3 * W) begin
      @(posedge clk);
      #1;
      k++;
      start = 1'b0;
      if (done === 1'b1) break;
      if (busy === 1'b1) busy_cnt++;
      check("sum_hold", 64'(sum), 64'(last_sum));
      if (k == poke_at) begin
        a     = 8'hAA;
        b     = 8'h55;
        sub   = 1'b1;
        start = 1'b1;
      end
    end
    check("done_latency", 64'(k), 64'(W));
    check("busy_cycles", 64'(busy_cnt), 64'(W));
    check("busy_low_at_done", 64'(busy), 64'd0);
    last_sum = next_sum;
  endtask

  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                    input logic tsub, input logic [W-1:0] esum, input logic ecout, input logic eovf);
    launch(1'b0, ta, tb_v, tcin, tsub, esum, ecout, eovf);
    wait_done(-1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    // async reset before any clock edge
    #2 rst = 1'b1;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_sum", 64'(sum), 64'd0);
    check("reset_cout", 64'(cout), 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // add / wrap / subtract vectors
    op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    op(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
    op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op(8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    op(8'h0F, 8'h10, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0);
    op(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);

    // ignored start while busy, then back-to-back start in the done cycle
    launch(1'b0, 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
    wait_done(2);
    launch(1'b1, 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);
    wait_done(-1);

    // abort mid-operation
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    check("abort_cout_ovf", 64'({cout, ovf}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    last_sum = '0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", 64'(done), 64'd0);
    end
    op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
